// File: rtl/fifo_serial_pkg.sv
// Shared definitions for the FIFO drain / serial transmit path.
// Holds the default word width so the FIFO and its reader agree, the
// transmitter state encoding, and a width helper for small counters.
package fifo_serial_pkg;

  // Data width of the upstream synchronous FIFO.
  localparam int FIFO_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,   // line high, waiting for en && !fifo_empty
    REQ,    // one-cycle FIFO read strobe
    LOAD,   // FIFO data valid, captured into the shift register
    START,  // start bit (low)
    DATA,   // DATA_W data bits, LSB first
    STOP    // stop bit (high)
  } state_t;

  // Counter width for a modulus of n; never narrower than one bit, so a
  // modulus of 1 still gets a legal (constant-zero) register.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_baud_tick.sv
// Bit-period timer for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick is high in the last cycle of each
// bit period. clr restarts the period so every state begins at count 0.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   clr   : synchronous clear; next cycle starts a fresh bit period
//   tick  : end-of-bit pulse (combinational from the count register)
module baud_tick
  import fifo_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With CLKS_PER_BIT == 1 the count is pinned at 0 and tick is always high.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO-to-UART serialiser.
// Pops one word at a time from a synchronous FIFO (rd_en / dout / empty,
// one cycle read latency) and sends it as: start bit (0), DATA_W data bits
// LSB first, stop bit (1); every bit lasts CLKS_PER_BIT clocks.
// All outputs are registered; their next values are decoded from the next
// state so they line up with the state they belong to.
// Ports:
//   clk, reset  : clock (rising edge), synchronous active-high reset
//   en          : allow a new word to start; only looked at in IDLE
//   fifo_dout   : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty  : FIFO empty flag, only looked at in IDLE
//   fifo_rd_en  : single-cycle read strobe (REQ state)
//   tx          : serial line, idles high
//   busy        : high in every state other than IDLE
// DATA_W must be >= 2; CLKS_PER_BIT must be >= 1.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int DATA_W       = FIFO_DATA_W,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy
);

  localparam int            BW       = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BW-1:0]     bit_idx, bit_idx_nxt;
  logic              tx_nxt, rd_en_nxt, busy_nxt;
  logic              tick, baud_clr;

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (baud_clr),
    .tick  (tick)
  );

  // Next state, datapath and registered-output decode.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;

    unique case (state)
      IDLE:  if (en && !fifo_empty) state_nxt = REQ;
      REQ:   state_nxt = LOAD;
      LOAD: begin
        // The read issued in REQ has landed on fifo_dout by now.
        shreg_nxt = fifo_dout;
        state_nxt = START;
      end
      START: if (tick) begin
        state_nxt   = DATA;
        bit_idx_nxt = '0;
      end
      DATA:  if (tick) begin
        shreg_nxt   = shreg >> 1;
        bit_idx_nxt = bit_idx + 1'b1;
        if (bit_idx == LAST_BIT) state_nxt = STOP;
      end
      STOP:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Restart the bit timer on every state change so each state's first
    // cycle is count 0; within DATA the timer simply wraps between bits.
    baud_clr  = (state_nxt != state);
    rd_en_nxt = (state_nxt == REQ);
    busy_nxt  = (state_nxt != IDLE);

    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_idx    <= bit_idx_nxt;
      tx         <= tx_nxt;
      fifo_rd_en <= rd_en_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Downstream consumer of the 16-bit synchronous FIFO.
- Drains the FIFO one word at a time through its rd_en/dout/empty interface.
- Serialises each word onto a single UART-style line: start bit, DATA_W data bits LSB first, stop bit.
- Sits between the FIFO read port and the board-level serial output.

Parameters:
DATA_W, 16, word width; must match the FIFO data width
CLKS_PER_BIT, 4, clk cycles per serial bit; must be >= 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  permits starting a new word; sampled only in IDLE
fifo_dout  input  DATA_W  FIFO read data; valid the cycle after fifo_rd_en is sampled high
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO read strobe; registered, single-cycle pulse
tx  output  1  serial line; idles high
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values (next edge with reset=1): state=IDLE, tx=1, fifo_rd_en=0, busy=0, shift register=0, counters=0.
- Reset has priority over every other event. Reset mid-frame: tx returns to 1 on that edge and the in-flight word is discarded. No FIFO read is issued on that edge.
- FSM states: IDLE, REQ, LOAD, START, DATA, STOP. All outputs are registered.
- IDLE: tx=1. If en=1 and fifo_empty=0, go to REQ; otherwise stay.
- REQ: exactly one cycle with fifo_rd_en=1. The FIFO samples it at the end of this cycle. Always go to LOAD.
- LOAD: one cycle with fifo_rd_en=0. fifo_dout is captured into the shift register at the end of the cycle. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shreg[0] for CLKS_PER_BIT cycles. At the end of each bit period, shift right and increment the bit index. After bit DATA_W-1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps, and clears on every state entry. With CLKS_PER_BIT=1 each bit lasts one cycle.
- Widths: baud counter = max(1,$clog2(CLKS_PER_BIT)); bit index = $clog2(DATA_W).
- Latency: if IDLE sees en&&!fifo_empty in cycle t, then fifo_rd_en=1 in t+1 and tx falls at the start of t+3.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles of START+DATA+STOP.
- Back-to-back words: minimum line idle between a stop bit and the next start bit is 3 cycles (IDLE, REQ, LOAD), all with tx=1.
- fifo_rd_en is never asserted while fifo_empty=1 as seen in IDLE. This block is the FIFO's only reader, so the FIFO cannot empty between REQ and LOAD.
- en deasserted mid-frame: the current frame completes and no new word is started.
- fifo_empty and en changes outside IDLE are ignored.
- busy=1 from REQ through the last STOP cycle inclusive.

Decomposition:
- Shared package fifo_serial_pkg: state enum (IDLE, REQ, LOAD, START, DATA, STOP) and the default DATA_W=16, so the FIFO and this block agree on width.
- One natural sub-module: baud_tick, a CLKS_PER_BIT counter with a synchronous clear that emits a one-cycle end-of-bit pulse. The FSM, shift register and bit index stay in the top module.

Test Plan:
1. Reset then idle: hold reset=1 for 2 cycles with fifo_empty=1 and en=1, release -> tx=1, busy=0, fifo_rd_en=0 for 50 cycles.
2. Single word: FIFO holds 16'h0055, CLKS_PER_BIT=4 -> exactly one fifo_rd_en pulse 1 cycle after IDLE sees !empty. tx falls 2 cycles after the pulse. Line shows 0 (start), 1,0,1,0,1,0,1,0, then eight 0s, then 1 (stop), each bit held 4 cycles. Frame is 72 cycles, then busy=0.
3. Back-to-back: FIFO holds 16'h0055 then 16'h0017 -> two rd_en pulses, two frames separated by exactly 3 idle-high cycles. Second frame data bits 1,1,1,0,1,0,0,0, then eight 0s. FIFO ends empty.
4. en gating: FIFO non-empty with en=0 -> no rd_en and tx=1. Raise en -> frame starts with the latency in scenario 2. Drop en mid-frame -> frame completes and no further read occurs.
5. Reset mid-frame: assert reset during DATA bit 5 of 16'h0055 -> next edge tx=1, busy=0, state IDLE. After release with the FIFO still non-empty, the next word is fetched normally.
6. CLKS_PER_BIT=1 build: word 16'hFFFF -> 18-cycle frame (0, sixteen 1s, 1) and correct rd_en timing.
